pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 108 ++++++++++
 tb/tb_pipe_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Elastic pipeline stage: a small in-order queue between two pipeline units
// with flush (drops counted), stall, and valid/ready handshakes on both sides.
module pipe_stage #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [PC_W-1:0]            in_pc_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       flush_i,
  input  logic                       stall_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [PC_W-1:0]            out_pc_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 2 ** PTR_W;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [PC_W-1:0]   pc_mem   [SLOTS];
  logic [DATA_W-1:0] data_mem [SLOTS];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [15:0]       drop_cnt;
  logic [PC_W-1:0]   last_pc;
  logic [DATA_W-1:0] last_data;

  logic        push;
  logic        pop;
  logic        empty;
  logic        full;
  logic [16:0] drop_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  assign in_ready_o  = !reset && !full && !flush_i;
  assign out_valid_o = !empty && !stall_i && !flush_i;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  assign drop_sum = {1'b0, drop_cnt} + 17'(count);

  // Empty stage keeps showing the last head it presented.
  assign out_pc_o   = empty ? last_pc : pc_mem[rd_ptr];
  assign out_data_o = empty ? last_data : data_mem[rd_ptr];

  assign count_o    = count;
  assign drop_cnt_o = drop_cnt;

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= in_pc_i;
      data_mem[wr_ptr] <= in_data_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      drop_cnt  <= '0;
      last_pc   <= '0;
      last_data <= '0;
    end else begin
      if (!empty) begin
        last_pc   <= pc_mem[rd_ptr];
        last_data <= data_mem[rd_ptr];
      end
      if (flush_i) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        unique case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: DEPTH 2/1/4/16 instances share stimulus and are
// checked each cycle against a queue scoreboard, plus a vector table.
module tb_pipe_stage;

  localparam int NI = 4;
  localparam int DEPTHS[NI] = '{2, 1, 4, 16};

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [63:0] pc;
    logic        fl;
    logic        st;
    logic        ordy;
    int          cnt;
    logic        rdy;
    logic        ov;
    logic        cp;
    logic [63:0] epc;
    int          drp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        stall = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_pc = '0;
  logic [63:0] in_data = '0;

  logic [NI-1:0]       rdy;
  logic [NI-1:0]       ovld;
  logic [NI-1:0][63:0] opc;
  logic [NI-1:0][63:0] odata;
  logic [NI-1:0][4:0]  cnt;
  logic [NI-1:0][15:0] drop;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D = DEPTHS[g];
    logic [$clog2(D+1)-1:0] c;
    pipe_stage #(
      .DATA_W(64),
      .PC_W(64),
      .DEPTH(D)
    ) dut (
      .clock(clock),
      .reset(reset),
      .in_valid_i(in_valid),
      .in_ready_o(rdy[g]),
      .in_pc_i(in_pc),
      .in_data_i(in_data),
      .flush_i(flush),
      .stall_i(stall),
      .out_valid_o(ovld[g]),
      .out_ready_i(out_ready),
      .out_pc_o(opc[g]),
      .out_data_o(odata[g]),
      .count_o(c),
      .drop_cnt_o(drop[g])
    );
    assign cnt[g] = 5'(c);
  end

  ent_t        mq[NI][$];
  ent_t        mlast[NI];
  logic [15:0] mdrop[NI];
  int          nchk = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Reference queue per instance, updated on the same edges as the DUTs.
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < NI; i++) begin
      int sz;
      int s;
      sz = mq[i].size();
      if (reset) begin
        mq[i].delete();
        mlast[i] = '0;
        mdrop[i] = '0;
      end else begin
        if (sz != 0) mlast[i] = mq[i][0];
        if (flush) begin
          s = int'(mdrop[i]) + sz;
          mdrop[i] = (s > 65535) ? 16'hFFFF : 16'(s);
          mq[i].delete();
        end else begin
          if (sz != 0 && !stall && out_ready)
            void'(mq[i].pop_front());
          if (in_valid && sz < DEPTHS[i])
            mq[i].push_back(ent_t'{in_pc, in_data});
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      int   sz;
      ent_t h;
      sz = mq[i].size();
      h  = (sz != 0) ? mq[i][0] : mlast[i];
      chk("sb_count", i, 64'(cnt[i]), 64'(sz));
      chk("sb_in_ready", i, 64'(rdy[i]),
          64'(!reset && sz < DEPTHS[i] && !flush));
      chk("sb_out_valid", i, 64'(ovld[i]),
          64'(sz != 0 && !stall && !flush));
      chk("sb_out_pc", i, opc[i], h.pc);
      chk("sb_out_data", i, odata[i], h.data);
      chk("sb_drop", i, 64'(drop[i]), 64'(mdrop[i]));
    end
  end

  function automatic vec_t mk(
    input logic iv, input logic [63:0] pc, input logic fl,
    input logic st, input logic o, input int c, input logic r,
    input logic v, input logic cp, input logic [63:0] ep, input int d
  );
    vec_t t;
    t.iv = iv; t.pc = pc; t.fl = fl; t.st = st; t.ordy = o;
    t.cnt = c; t.rdy = r; t.ov = v; t.cp = cp; t.epc = ep; t.drp = d;
    return t;
  endfunction

  vec_t tv[19];

  initial begin
    int guard;
    int k;
    //        iv  pc        fl st or  cnt rdy ov cp epc       drop
    tv[0]  = mk(1, 64'h1000, 0, 0, 0, 0, 1, 0, 0, 64'h0,    0);
    tv[1]  = mk(1, 64'h1004, 0, 0, 0, 1, 1, 1, 1, 64'h1000, 0);
    tv[2]  = mk(0, 64'h0,    0, 0, 0, 2, 0, 1, 1, 64'h1000, 0);
    tv[3]  = mk(1, 64'h1008, 0, 0, 1, 2, 0, 1, 1, 64'h1000, 0);
    tv[4]  = mk(1, 64'h1008, 0, 0, 1, 1, 1, 1, 1, 64'h1004, 0);
    tv[5]  = mk(1, 64'h1008, 0, 0, 1, 1, 1, 1, 1, 64'h1008, 0);
    tv[6]  = mk(0, 64'h0,    0, 0, 1, 1, 1, 1, 1, 64'h1008, 0);
    tv[7]  = mk(0, 64'h0,    0, 0, 0, 0, 1, 0, 1, 64'h1008, 0);
    tv[8]  = mk(1, 64'h2010, 0, 0, 0, 0, 1, 0, 1, 64'h1008, 0);
    tv[9]  = mk(1, 64'h2014, 0, 0, 0, 1, 1, 1, 1, 64'h2010, 0);
    tv[10] = mk(1, 64'h2018, 1, 0, 0, 2, 0, 0, 1, 64'h2010, 0);
    tv[11] = mk(0, 64'h0,    0, 0, 0, 0, 1, 0, 1, 64'h2010, 2);
    tv[12] = mk(1, 64'h3000, 0, 0, 0, 0, 1, 0, 0, 64'h0,    2);
    tv[13] = mk(0, 64'h0,    0, 1, 1, 1, 1, 0, 1, 64'h3000, 2);
    tv[14] = mk(0, 64'h0,    0, 1, 1, 1, 1, 0, 1, 64'h3000, 2);
    tv[15] = mk(0, 64'h0,    0, 1, 1, 1, 1, 0, 1, 64'h3000, 2);
    tv[16] = mk(0, 64'h0,    0, 1, 1, 1, 1, 0, 1, 64'h3000, 2);
    tv[17] = mk(0, 64'h0,    0, 0, 1, 1, 1, 1, 1, 64'h3000, 2);
    tv[18] = mk(0, 64'h0,    0, 0, 0, 0, 1, 0, 1, 64'h3000, 2);

    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_count", 0, 64'(cnt[0]), 64'd0);
    chk("rst_in_ready", 0, 64'(rdy[0]), 64'd0);
    chk("rst_out_pc", 0, opc[0], 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int v = 0; v < 19; v++) begin
      @(posedge clock);
      #1;
      in_valid  = tv[v].iv;
      in_pc     = tv[v].pc;
      in_data   = ~tv[v].pc;
      flush     = tv[v].fl;
      stall     = tv[v].st;
      out_ready = tv[v].ordy;
      @(negedge clock);
      #1;
      chk("tv_count", v, 64'(cnt[0]), 64'(tv[v].cnt));
      chk("tv_in_ready", v, 64'(rdy[0]), 64'(tv[v].rdy));
      chk("tv_out_valid", v, 64'(ovld[0]), 64'(tv[v].ov));
      chk("tv_drop", v, 64'(drop[0]), 64'(tv[v].drp));
      if (tv[v].cp) begin
        chk("tv_out_pc", v, opc[0], tv[v].epc);
        chk("tv_out_data", v, odata[0], ~tv[v].epc);
      end
    end

    // One entry held, then reset raised between edges.
    @(posedge clock);
    #1;
    in_valid = 1'b1; in_pc = 64'h4000; in_data = ~64'h4000;
    out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    #1 chk("held_one", 0, 64'(cnt[0]), 64'd1);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_count", i, 64'(cnt[i]), 64'd0);
      chk("arst_valid", i, 64'(ovld[i]), 64'd0);
      chk("arst_ready", i, 64'(rdy[i]), 64'd0);
      chk("arst_pc", i, opc[i], 64'd0);
      chk("arst_data", i, odata[i], 64'd0);
      chk("arst_drop", i, 64'(drop[i]), 64'd0);
    end
    @(negedge clock);
    #1;
    reset = 1'b0;
    in_valid = 1'b1; in_pc = 64'h5000; in_data = ~64'h5000;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(negedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("first_push_count", i, 64'(cnt[i]), 64'd1);
      chk("first_push_pc", i, opc[i], 64'h5000);
    end
    @(posedge clock);
    #1 out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;

    // Fill and flush repeatedly until the DEPTH=16 instance reaches 0xFFFE.
    guard = 0;
    while (mdrop[3] < 16'hFFFE && guard < 5000) begin
      k = 32'hFFFE - int'(mdrop[3]);
      if (k > 16) k = 16;
      in_valid = 1'b1;
      for (int j = 0; j < k; j++) begin
        in_pc   = 64'($urandom);
        in_data = {$urandom, $urandom};
        @(posedge clock);
        #1;
      end
      in_valid = 1'b0;
      flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      guard++;
    end
    nchk++;
    if (guard >= 5000) begin
      nerr++;
      $display("FAIL preload_budget: got %0d iterations limit 5000", guard);
    end
    @(negedge clock);
    #1 chk("drop_preload", 3, 64'(drop[3]), 64'hFFFE);
    for (int r = 0; r < 2; r++) begin
      @(posedge clock);
      #1;
      in_valid = 1'b1;
      repeat (2) begin
        in_pc = 64'($urandom);
        @(posedge clock);
        #1;
      end
      in_valid = 1'b0;
      flush = 1'b1;
      @(posedge clock);
      #1 flush = 1'b0;
      @(negedge clock);
      #1 chk("drop_sat", 3, 64'(drop[3]), 64'hFFFF);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
